// File: rtl/cam_op_scheduler.sv
// Shares the single CAM op port between a lookup stream and an update stream.
// Lookups win by default; updates are forced in after a lookup burst, and a drain mode quiesces the CAM.
module cam_op_scheduler #(
    parameter int KEY_SIZE         = 8,
    parameter int VALUE_SIZE       = 32,
    parameter int USER_WIDTH       = 4,
    parameter int MAX_LOOKUP_BURST = 4,
    parameter int MAX_OUTSTANDING  = 4
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [KEY_SIZE-1:0]                    lookup_req_index,
    input  logic [USER_WIDTH-1:0]                  lookup_req_user,
    input  logic                                   lookup_req_valid,
    output logic                                   lookup_req_ready,
    input  logic [KEY_SIZE-1:0]                    update_req_index,
    input  logic [VALUE_SIZE-1:0]                  update_req_data,
    input  logic [USER_WIDTH-1:0]                  update_req_user,
    input  logic                                   update_req_valid,
    output logic                                   update_req_ready,
    output logic                                   cam_op_valid,
    output logic                                   cam_op_write,
    output logic [KEY_SIZE-1:0]                    cam_op_index,
    output logic [VALUE_SIZE-1:0]                  cam_op_data,
    output logic [USER_WIDTH-1:0]                  cam_op_user,
    input  logic                                   cam_op_ready,
    input  logic                                   cam_rsp_valid,
    input  logic                                   cam_rsp_ready,
    input  logic                                   flush_req,
    output logic                                   flush_done,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding,
    output logic                                   err_underflow
);

    localparam int OUT_W   = $clog2(MAX_OUTSTANDING + 1);
    localparam int BURST_W = $clog2(MAX_LOOKUP_BURST + 1);

    typedef enum logic [1:0] {
        RUN,
        FORCE_UPD,
        DRAIN
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [BURST_W-1:0]   burst_cnt;
    logic [BURST_W:0]     burst_inc;
    logic                 burst_hit;
    logic                 load_en;
    logic                 credit_ok;
    logic                 lk_elig;
    logic                 lk_hs;
    logic                 up_hs;
    logic                 rsp_hs;
    logic                 drain_idle;
    logic                 enter_drain;

    assign load_en    = !cam_op_valid || cam_op_ready;
    assign credit_ok  = outstanding < OUT_W'(MAX_OUTSTANDING);
    assign lk_elig    = lookup_req_valid && credit_ok;
    assign lk_hs      = lookup_req_valid && lookup_req_ready;
    assign up_hs      = update_req_valid && update_req_ready;
    assign rsp_hs     = cam_rsp_valid && cam_rsp_ready;
    assign drain_idle = !cam_op_valid && (outstanding == '0);
    assign burst_inc  = {1'b0, burst_cnt} + (BURST_W+1)'(1);
    assign burst_hit  = burst_inc >= (BURST_W+1)'(MAX_LOOKUP_BURST);
    assign enter_drain = (state != DRAIN) && (state_nxt == DRAIN);

    // Readys are gated by rst so every output reads 0 while reset is held.
    assign lookup_req_ready = !rst && (state == RUN) && load_en && credit_ok;
    assign update_req_ready = !rst && load_en &&
                              (((state == RUN) && !lk_elig) || (state == FORCE_UPD));

    always_comb begin
        state_nxt  = state;
        flush_done = 1'b0;
        case (state)
            RUN: begin
                if (flush_req)
                    state_nxt = DRAIN;
                else if (lk_hs && burst_hit && update_req_valid)
                    state_nxt = FORCE_UPD;
            end
            FORCE_UPD: begin
                if (flush_req)
                    state_nxt = DRAIN;
                else if (up_hs || !update_req_valid)
                    state_nxt = RUN;
            end
            DRAIN: begin
                if (drain_idle) begin
                    flush_done = 1'b1;
                    state_nxt  = RUN;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= RUN;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            burst_cnt <= '0;
        else if (enter_drain || up_hs)
            burst_cnt <= '0;
        else if (lk_hs && (burst_cnt < BURST_W'(MAX_LOOKUP_BURST)))
            burst_cnt <= burst_inc[BURST_W-1:0];
    end

    // A lookup handshake cannot happen at full credit, so the increment never wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outstanding   <= '0;
            err_underflow <= 1'b0;
        end else begin
            if (lk_hs && !rsp_hs)
                outstanding <= outstanding + OUT_W'(1);
            else if (!lk_hs && rsp_hs && (outstanding != '0))
                outstanding <= outstanding - OUT_W'(1);
            if (rsp_hs && (outstanding == '0))
                err_underflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cam_op_valid <= 1'b0;
            cam_op_write <= 1'b0;
            cam_op_index <= '0;
            cam_op_data  <= '0;
            cam_op_user  <= '0;
        end else if (load_en) begin
            cam_op_valid <= lk_hs || up_hs;
            if (lk_hs) begin
                cam_op_write <= 1'b0;
                cam_op_index <= lookup_req_index;
                cam_op_data  <= '0;
                cam_op_user  <= lookup_req_user;
            end else if (up_hs) begin
                cam_op_write <= 1'b1;
                cam_op_index <= update_req_index;
                cam_op_data  <= update_req_data;
                cam_op_user  <= update_req_user;
            end
        end
    end

endmodule

// File: tb/tb_cam_op_scheduler.sv
// Directed bench for cam_op_scheduler: arbitration, burst limit, credits, backpressure, drain, underflow, reset.
// Inputs change on the falling edge; outputs are sampled on the falling edge or 1 time unit after it.
module tb_cam_op_scheduler;

    logic        clk;
    logic        rst;
    logic [7:0]  lookup_req_index;
    logic [3:0]  lookup_req_user;
    logic        lookup_req_valid;
    logic        lookup_req_ready;
    logic [7:0]  update_req_index;
    logic [31:0] update_req_data;
    logic [3:0]  update_req_user;
    logic        update_req_valid;
    logic        update_req_ready;
    logic        cam_op_valid;
    logic        cam_op_write;
    logic [7:0]  cam_op_index;
    logic [31:0] cam_op_data;
    logic [3:0]  cam_op_user;
    logic        cam_op_ready;
    logic        cam_rsp_valid;
    logic        cam_rsp_ready;
    logic        flush_req;
    logic        flush_done;
    logic [2:0]  outstanding;
    logic        err_underflow;

    int checks = 0;
    int errors = 0;

    cam_op_scheduler dut (
        .clk              (clk),
        .rst              (rst),
        .lookup_req_index (lookup_req_index),
        .lookup_req_user  (lookup_req_user),
        .lookup_req_valid (lookup_req_valid),
        .lookup_req_ready (lookup_req_ready),
        .update_req_index (update_req_index),
        .update_req_data  (update_req_data),
        .update_req_user  (update_req_user),
        .update_req_valid (update_req_valid),
        .update_req_ready (update_req_ready),
        .cam_op_valid     (cam_op_valid),
        .cam_op_write     (cam_op_write),
        .cam_op_index     (cam_op_index),
        .cam_op_data      (cam_op_data),
        .cam_op_user      (cam_op_user),
        .cam_op_ready     (cam_op_ready),
        .cam_rsp_valid    (cam_rsp_valid),
        .cam_rsp_ready    (cam_rsp_ready),
        .flush_req        (flush_req),
        .flush_done       (flush_done),
        .outstanding      (outstanding),
        .err_underflow    (err_underflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Lookup / update pattern for the burst test: 1 = update op.
    bit exp_wr [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        rst              = 1'b1;
        lookup_req_index = '0;
        lookup_req_user  = '0;
        lookup_req_valid = 1'b0;
        update_req_index = '0;
        update_req_data  = '0;
        update_req_user  = '0;
        update_req_valid = 1'b0;
        cam_op_ready     = 1'b0;
        cam_rsp_valid    = 1'b0;
        cam_rsp_ready    = 1'b1;
        flush_req        = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_op_valid", cam_op_valid, 0);
        check("rst_outstanding", outstanding, 0);
        check("rst_err", err_underflow, 0);
        check("rst_lk_ready", lookup_req_ready, 0);
        check("rst_up_ready", update_req_ready, 0);
        check("rst_flush_done", flush_done, 0);
        @(negedge clk);
        rst = 1'b0;

        // T1: eight back-to-back lookups, one response per cycle after the first
        @(negedge clk);
        cam_op_ready     = 1'b1;
        lookup_req_valid = 1'b1;
        lookup_req_index = 8'd0;
        lookup_req_user  = 4'h1;
        #1 check("t1_lk_ready", lookup_req_ready, 1);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            check("t1_op_valid", cam_op_valid, 1);
            check("t1_op_write", cam_op_write, 0);
            check("t1_op_index", cam_op_index, 64'(k - 1));
            check("t1_op_data", cam_op_data, 0);
            check("t1_outstanding", outstanding, 1);
            cam_rsp_valid = 1'b1;
            if (k < 8)
                lookup_req_index = 8'(k);
            else
                lookup_req_valid = 1'b0;
        end
        @(negedge clk);
        check("t1_idle_valid", cam_op_valid, 0);
        check("t1_idle_outstanding", outstanding, 0);
        check("t1_no_underflow", err_underflow, 0);
        cam_rsp_valid = 1'b0;

        // Single update clears the saturated burst count
        update_req_valid = 1'b1;
        update_req_index = 8'hC3;
        update_req_data  = 32'h1234_5678;
        update_req_user  = 4'h7;
        #1 check("upd_ready", update_req_ready, 1);
        @(negedge clk);
        check("upd_op_valid", cam_op_valid, 1);
        check("upd_op_write", cam_op_write, 1);
        check("upd_op_index", cam_op_index, 8'hC3);
        check("upd_op_data", cam_op_data, 32'h1234_5678);
        check("upd_op_user", cam_op_user, 4'h7);

        // T2: both streams valid -> L,L,L,L,U repeating; responses follow each lookup
        lookup_req_valid = 1'b1;
        lookup_req_index = 8'h11;
        lookup_req_user  = 4'h1;
        update_req_index = 8'h22;
        update_req_data  = 32'hDEAD_BEEF;
        update_req_user  = 4'h2;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check("t2_op_valid", cam_op_valid, 1);
            check("t2_op_write", cam_op_write, 64'(exp_wr[c]));
            check("t2_op_data", cam_op_data, exp_wr[c] ? 32'hDEAD_BEEF : 32'h0);
            cam_rsp_valid = !exp_wr[c];
            if (c == 3) begin
                #1;
                check("t2_force_lk_ready", lookup_req_ready, 0);
                check("t2_force_up_ready", update_req_ready, 1);
            end
        end
        check("t2_outstanding", outstanding, 0);
        lookup_req_valid = 1'b0;
        update_req_valid = 1'b0;
        @(negedge clk);
        check("t2_idle_valid", cam_op_valid, 0);

        // T3: no responses -> credit limit of four
        lookup_req_valid = 1'b1;
        lookup_req_index = 8'h30;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("t3_outstanding", outstanding, (c < 3) ? 64'(c + 1) : 64'd4);
        end
        check("t3_lk_ready_full", lookup_req_ready, 0);
        check("t3_op_empty", cam_op_valid, 0);
        cam_rsp_valid = 1'b1;
        #1 check("t3_lk_ready_rsp_cycle", lookup_req_ready, 0);
        @(negedge clk);
        check("t3_out_after_rsp", outstanding, 3);
        cam_rsp_valid = 1'b0;
        #1 check("t3_lk_ready_fifth", lookup_req_ready, 1);
        @(negedge clk);
        check("t3_fifth_issued", cam_op_valid, 1);
        check("t3_out_full_again", outstanding, 4);
        lookup_req_valid = 1'b0;
        cam_rsp_valid    = 1'b1;
        @(negedge clk);
        @(negedge clk);
        cam_rsp_valid = 1'b0;
        check("t3_out_drained", outstanding, 2);

        // T4: backpressure holds the op and blocks inputs
        cam_op_ready     = 1'b0;
        lookup_req_valid = 1'b1;
        lookup_req_index = 8'h5A;
        lookup_req_user  = 4'h3;
        #1 check("t4_lk_ready_empty", lookup_req_ready, 1);
        @(negedge clk);
        lookup_req_index = 8'h5B;
        lookup_req_user  = 4'h4;
        #1 check("t4_lk_ready_held", lookup_req_ready, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t4_hold_valid", cam_op_valid, 1);
            check("t4_hold_index", cam_op_index, 8'h5A);
            check("t4_hold_user", cam_op_user, 4'h3);
            check("t4_hold_lk_ready", lookup_req_ready, 0);
            check("t4_hold_outstanding", outstanding, 3);
        end
        cam_op_ready = 1'b1;
        #1 check("t4_release_lk_ready", lookup_req_ready, 1);
        @(negedge clk);
        check("t4_next_index", cam_op_index, 8'h5B);
        check("t4_next_user", cam_op_user, 4'h4);
        check("t4_outstanding", outstanding, 4);
        lookup_req_valid = 1'b0;
        cam_rsp_valid    = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        cam_rsp_valid = 1'b0;
        check("t4_out_drained", outstanding, 1);
        check("t4_op_empty", cam_op_valid, 0);

        // T5: flush with an op held and two lookups in flight
        cam_op_ready     = 1'b0;
        lookup_req_valid = 1'b1;
        lookup_req_index = 8'h66;
        flush_req        = 1'b1;
        #1 check("t5_same_cycle_hs", lookup_req_ready, 1);
        @(negedge clk);
        flush_req        = 1'b0;
        update_req_valid = 1'b1;
        #1;
        check("t5_drain_lk_ready", lookup_req_ready, 0);
        check("t5_drain_up_ready", update_req_ready, 0);
        check("t5_done_held", flush_done, 0);
        check("t5_outstanding", outstanding, 2);
        check("t5_op_held", cam_op_valid, 1);
        @(negedge clk);
        cam_op_ready = 1'b1;
        #1 check("t5_done_releasing", flush_done, 0);
        @(negedge clk);
        check("t5_op_gone", cam_op_valid, 0);
        cam_rsp_valid = 1'b1;
        #1 check("t5_done_out2", flush_done, 0);
        @(negedge clk);
        #1 check("t5_done_out1", flush_done, 0);
        @(negedge clk);
        cam_rsp_valid = 1'b0;
        #1;
        check("t5_done_pulse", flush_done, 1);
        check("t5_done_lk_ready", lookup_req_ready, 0);
        @(negedge clk);
        #1;
        check("t5_done_cleared", flush_done, 0);
        check("t5_run_lk_ready", lookup_req_ready, 1);
        check("t5_run_up_ready", update_req_ready, 0);
        @(negedge clk);
        check("t5_resume_op", cam_op_valid, 1);
        check("t5_resume_index", cam_op_index, 8'h66);
        lookup_req_valid = 1'b0;
        update_req_valid = 1'b0;
        cam_rsp_valid    = 1'b1;
        @(negedge clk);
        cam_rsp_valid = 1'b0;
        check("t5_final_out", outstanding, 0);

        // T6: underflow is sticky, then reset in the middle of a burst
        cam_rsp_valid = 1'b1;
        @(negedge clk);
        cam_rsp_valid = 1'b0;
        check("t6_underflow", err_underflow, 1);
        check("t6_out_zero", outstanding, 0);
        @(negedge clk);
        check("t6_sticky", err_underflow, 1);
        lookup_req_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("t6_pre_rst_out", outstanding, 2);
        rst = 1'b1;
        #1;
        check("t6_rst_op_valid", cam_op_valid, 0);
        check("t6_rst_out", outstanding, 0);
        check("t6_rst_err", err_underflow, 0);
        check("t6_rst_lk_ready", lookup_req_ready, 0);
        @(negedge clk);
        check("t6_rst_held_valid", cam_op_valid, 0);
        check("t6_rst_held_out", outstanding, 0);
        rst = 1'b0;
        #1 check("t6_post_rst_lk_ready", lookup_req_ready, 1);
        @(negedge clk);
        check("t6_post_rst_op", cam_op_valid, 1);
        check("t6_post_rst_out", outstanding, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not reach its end");
        $fatal(1, "timeout");
    end

endmodule
